// File: rtl/parafuzz_probe_pkg.sv
// Shared types and constants for the probe stream packer.
// Optional feature macro: PROBE_TIMESTAMP_EN (adds a 32-bit cycle stamp to each FIFO entry).
package parafuzz_probe_pkg;

  typedef logic [63:0] probe_word_t;

  localparam logic [15:0] MARKER_TAG = 16'hD70F;
  localparam int          STAMP_W    = 32;

`ifdef PROBE_TIMESTAMP_EN
  localparam int ENTRY_W = 64 + STAMP_W;
`else
  localparam int ENTRY_W = 64;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    MARKER = 2'd2
  } pack_state_e;

  // In-band drop report: tag in the top 16 bits, zero-extended count below.
  function automatic probe_word_t make_marker(input logic [47:0] cnt);
    return {MARKER_TAG, cnt};
  endfunction

endpackage

// File: rtl/probe_fifo.sv
// Circular buffer with up to NUM_LANES writes and one read per cycle.
// Writers present already-compacted slots; slots [0, wr_cnt) are stored in order.
// The caller guarantees wr_cnt never exceeds free space and rd_en only when a word exists
// (either stored or being written this cycle, which covers the empty-FIFO bypass case).
module probe_fifo #(
  parameter  int WIDTH     = 64,
  parameter  int DEPTH     = 16,
  parameter  int NUM_LANES = 2,
  localparam int LANE_W    = $clog2(NUM_LANES + 1),
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [LANE_W-1:0]                wr_cnt,
  input  logic [NUM_LANES-1:0][WIDTH-1:0]  wr_data,
  input  logic                             rd_en,
  output logic [WIDTH-1:0]                 rd_data,
  output logic [CNT_W-1:0]                 count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(wr_cnt);
    rd_ptr_d = rd_ptr_q + PTR_W'(rd_en);
    count_d  = count_q + CNT_W'(wr_cnt) - CNT_W'(rd_en);
  end

  // Control registers.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array: write the first wr_cnt slots at consecutive addresses.
  // NOTE: storage has no reset; count_q alone defines which entries are valid.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_LANES; k++) begin
      if (LANE_W'(k) < wr_cnt) begin
        mem_q[wr_ptr_q + PTR_W'(k)] <= wr_data[k];
      end
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/probe_stream_packer.sv
// Packs valid probe lanes into a FIFO and serialises them one word per cycle onto the
// probe buffer write port. Words lost to overflow are counted and reported in-band as a
// marker word. Optional feature macro: PROBE_TIMESTAMP_EN (adds out_stamp port).
module probe_stream_packer
  import parafuzz_probe_pkg::*;
#(
  parameter int NUM_LANES = 2,
  parameter int DEPTH     = 16,
  parameter int DROP_W    = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_LANES-1:0]    in_valid,
  input  logic [64*NUM_LANES-1:0] in_data,
  input  logic                    flush,
  output logic                    out_wen,
  output logic [63:0]             out_write,
`ifdef PROBE_TIMESTAMP_EN
  output logic [31:0]             out_stamp,
`endif
  output logic                    drop_sat
);

  localparam int LANE_W = $clog2(NUM_LANES + 1);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int DSUM_W = DROP_W + 1;
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  pack_state_e state_q, state_d;

  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d, drop_base;
  logic [DSUM_W-1:0] drop_sum;
  logic              drop_sat_q, drop_sat_d;
  logic              out_wen_q, out_wen_d;
  probe_word_t       out_write_q, out_write_d;

  logic [NUM_LANES-1:0][ENTRY_W-1:0] slot_entry;
  logic [ENTRY_W-1:0]                lane_entry;
  logic [ENTRY_W-1:0]                head_entry;
  logic [ENTRY_W-1:0]                fifo_rd_data;
  logic [LANE_W-1:0]                 valid_cnt, accepted, dropped;
  logic [CNT_W-1:0]                  fifo_count, free, count_next;
  logic                              pop, go_marker;

`ifdef PROBE_TIMESTAMP_EN
  logic [STAMP_W-1:0] cyc_q, cyc_d;
  logic [STAMP_W-1:0] out_stamp_q, out_stamp_d;
`endif

  // Lane compaction: valid lanes fill slots 0,1,.. in ascending lane order.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    valid_cnt  = '0;
    slot_entry = '0;
    lane_entry = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
`ifdef PROBE_TIMESTAMP_EN
      lane_entry = {cyc_q, in_data[64*i +: 64]};
`else
      lane_entry = in_data[64*i +: 64];
`endif
      if (in_valid[i]) begin
        for (int s = 0; s < NUM_LANES; s++) begin
          if (valid_cnt == LANE_W'(s)) slot_entry[s] = lane_entry;
        end
        valid_cnt = valid_cnt + LANE_W'(1);
      end
    end
  end

  // Admission: only space free at the start of the cycle counts; a same-cycle pop is not credited.
  always_comb begin
    free = CNT_W'(DEPTH) - fifo_count;
    if (CNT_W'(valid_cnt) <= free) accepted = valid_cnt;
    else                           accepted = LANE_W'(free);
    dropped = valid_cnt - accepted;
  end

  // Saturating drop counter; the marker cycle restarts it from this cycle's drops only.
  always_comb begin
    drop_base = (state_q == MARKER) ? '0 : drop_cnt_q;
    drop_sum  = {1'b0, drop_base} + DSUM_W'(dropped);
    if (drop_sum[DROP_W]) drop_cnt_d = DROP_MAX;
    else                  drop_cnt_d = drop_sum[DROP_W-1:0];
    drop_sat_d = ((state_q == MARKER) ? 1'b0 : drop_sat_q) | (drop_cnt_d == DROP_MAX);
  end

  // An empty FIFO forwards the first arriving slot directly, giving one-cycle latency.
  assign head_entry = (fifo_count == '0) ? slot_entry[0] : fifo_rd_data;

  probe_fifo #(
    .WIDTH     (ENTRY_W),
    .DEPTH     (DEPTH),
    .NUM_LANES (NUM_LANES)
  ) u_fifo (
    .clk     (clock),
    .rst_n   (reset),
    .wr_cnt  (accepted),
    .wr_data (slot_entry),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .count   (fifo_count)
  );

`ifdef PROBE_TIMESTAMP_EN
  // Free-running cycle counter used to stamp accepted words.
  always_comb cyc_d = cyc_q + STAMP_W'(1);
`endif

  // FSM output logic: decide pop or marker and build the next registered output word.
  always_comb begin
    go_marker   = 1'b0;
    pop         = 1'b0;
    out_wen_d   = 1'b0;
    out_write_d = out_write_q;
`ifdef PROBE_TIMESTAMP_EN
    out_stamp_d = out_stamp_q;
`endif
    unique case (state_q)
      IDLE, DRAIN: begin
        if ((drop_cnt_q != '0) && (flush || (state_q == IDLE))) begin
          go_marker = 1'b1;
        end else if ((fifo_count != '0) || (accepted != '0)) begin
          pop         = 1'b1;
          out_wen_d   = 1'b1;
          out_write_d = head_entry[63:0];
`ifdef PROBE_TIMESTAMP_EN
          out_stamp_d = head_entry[64 +: STAMP_W];
`endif
        end
      end
      MARKER: begin
        out_wen_d   = 1'b1;
        out_write_d = make_marker(48'(drop_cnt_q));
`ifdef PROBE_TIMESTAMP_EN
        out_stamp_d = cyc_q;
`endif
      end
      default: ;
    endcase
  end

  // FSM next-state logic.
  always_comb begin
    count_next = fifo_count + CNT_W'(accepted) - CNT_W'(pop);
    state_d    = state_q;
    unique case (state_q)
      IDLE, DRAIN: begin
        if (go_marker)                state_d = MARKER;
        else if (count_next == '0)    state_d = (drop_cnt_d != '0) ? MARKER : IDLE;
        else                          state_d = DRAIN;
      end
      MARKER:  state_d = (count_next != '0) ? DRAIN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state register plus drop accounting and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      drop_cnt_q  <= '0;
      drop_sat_q  <= 1'b0;
      out_wen_q   <= 1'b0;
      out_write_q <= '0;
`ifdef PROBE_TIMESTAMP_EN
      cyc_q       <= '0;
      out_stamp_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      drop_cnt_q  <= drop_cnt_d;
      drop_sat_q  <= drop_sat_d;
      out_wen_q   <= out_wen_d;
      out_write_q <= out_write_d;
`ifdef PROBE_TIMESTAMP_EN
      cyc_q       <= cyc_d;
      out_stamp_q <= out_stamp_d;
`endif
    end
  end

  assign out_wen   = out_wen_q;
  assign out_write = out_write_q;
  assign drop_sat  = drop_sat_q;
`ifdef PROBE_TIMESTAMP_EN
  assign out_stamp = out_stamp_q;
`endif

endmodule
